// File: rtl/id_decode_pipe.sv
// Decode stage with ID/EX output register, one-entry skid buffer, load-use bubble
// insertion and multi-port writeback bypass that also refreshes held entries.
`ifndef CONTROL_SIGNALS_WIDTH
`define CONTROL_SIGNALS_WIDTH 8
`endif

module control_unit #(
  parameter int CTRL_W = 8
) (
  input  logic [6:0]        opcode_i,
  output logic [CTRL_W-1:0] ctrl_o
);
  // {alu_r, jump, branch, mem_to_reg, mem_read, mem_write, alu_src, reg_write}
  logic [7:0] base;

  always_comb begin
    base = 8'h00;
    case (opcode_i)
      7'b0110011: base = 8'h81;
      7'b0010011: base = 8'h03;
      7'b0000011: base = 8'h1B;
      7'b0100011: base = 8'h06;
      7'b1100011: base = 8'h20;
      7'b1101111: base = 8'h41;
      7'b1100111: base = 8'h43;
      7'b0110111: base = 8'h03;
      7'b0010111: base = 8'h03;
      default:    base = 8'h00;
    endcase
    ctrl_o = CTRL_W'(base);
  end
endmodule

module immediate_generator (
  input  logic [31:0] instr_i,
  output logic [31:0] imm_o
);
  always_comb begin
    imm_o = 32'd0;
    case (instr_i[6:0])
      7'b0010011, 7'b0000011, 7'b1100111:
        imm_o = {{20{instr_i[31]}}, instr_i[31:20]};
      7'b0100011:
        imm_o = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      7'b1100011:
        imm_o = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
      7'b0110111, 7'b0010111:
        imm_o = {instr_i[31:12], 12'd0};
      7'b1101111:
        imm_o = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
      default:
        imm_o = 32'd0;
    endcase
  end
endmodule

module id_decode_pipe #(
  parameter int NUM_WB      = 2,
  parameter int CTRL_W      = `CONTROL_SIGNALS_WIDTH,
  parameter int MEMREAD_BIT = 3
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_pc,
  input  logic [31:0]          in_instruction,
  output logic [4:0]           rs1_addr,
  output logic [4:0]           rs2_addr,
  input  logic [31:0]          rs1_data,
  input  logic [31:0]          rs2_data,
  input  logic [NUM_WB-1:0]    wb_reg_write,
  input  logic [5*NUM_WB-1:0]  wb_rd_addr,
  input  logic [32*NUM_WB-1:0] wb_rd_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_pc,
  output logic [31:0]          out_instruction,
  output logic [31:0]          out_immediate,
  output logic [31:0]          out_rs1_data,
  output logic [31:0]          out_rs2_data,
  output logic [4:0]           out_rd_addr,
  output logic [4:0]           out_rs1_addr,
  output logic [4:0]           out_rs2_addr,
  output logic [CTRL_W-1:0]    out_ctrl,
  output logic                 load_use_stall
);

  typedef struct packed {
    logic [31:0]       pc;
    logic [31:0]       instr;
    logic [31:0]       imm;
    logic [31:0]       rs1_val;
    logic [31:0]       rs2_val;
    logic [4:0]        rd;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [CTRL_W-1:0] ctrl;
  } entry_t;

  function automatic entry_t bubble();
    entry_t e;
    e       = '0;
    e.instr = 32'h0000_0013;
    return e;
  endfunction

  // Walk from the oldest port down so the lowest matching index wins.
  function automatic logic [31:0] byp(input logic [4:0] addr, input logic [31:0] regdata);
    logic [31:0] r;
    r = regdata;
    for (int i = NUM_WB - 1; i >= 0; i--) begin
      if (wb_reg_write[i] && (wb_rd_addr[i*5 +: 5] == addr) && (addr != 5'd0))
        r = wb_rd_data[i*32 +: 32];
    end
    return r;
  endfunction

  function automatic entry_t snoop(input entry_t e);
    entry_t s;
    s         = e;
    s.rs1_val = byp(e.rs1, e.rs1_val);
    s.rs2_val = byp(e.rs2, e.rs2_val);
    return s;
  endfunction

  entry_t            out_q, out_d, skid_q, skid_d;
  logic              out_valid_q, out_valid_d, skid_valid_q, skid_valid_d;
  entry_t            in_entry, out_held, skid_held;
  logic [CTRL_W-1:0] dec_ctrl;
  logic [31:0]       dec_imm;
  logic              accept, out_load;

  control_unit #(.CTRL_W(CTRL_W)) u_ctrl (
    .opcode_i (in_instruction[6:0]),
    .ctrl_o   (dec_ctrl)
  );

  immediate_generator u_imm (
    .instr_i (in_instruction),
    .imm_o   (dec_imm)
  );

  assign rs1_addr = in_instruction[19:15];
  assign rs2_addr = in_instruction[24:20];

  // Conservative: rs2 is compared even for formats that do not read it.
  assign load_use_stall = out_valid_q && out_q.ctrl[MEMREAD_BIT] && (out_q.rd != 5'd0) &&
                          ((out_q.rd == rs1_addr) || (out_q.rd == rs2_addr));

  assign in_ready = !skid_valid_q && !load_use_stall && !flush;
  assign accept   = in_valid && in_ready;
  assign out_load = !out_valid_q || out_ready;

  always_comb begin
    in_entry         = '0;
    in_entry.pc      = in_pc;
    in_entry.instr   = in_instruction;
    in_entry.imm     = dec_imm;
    in_entry.rs1_val = byp(rs1_addr, rs1_data);
    in_entry.rs2_val = byp(rs2_addr, rs2_data);
    in_entry.rd      = in_instruction[11:7];
    in_entry.rs1     = rs1_addr;
    in_entry.rs2     = rs2_addr;
    in_entry.ctrl    = dec_ctrl;
  end

  assign out_held  = snoop(out_q);
  assign skid_held = snoop(skid_q);

  always_comb begin
    out_d        = out_held;
    out_valid_d  = out_valid_q;
    skid_d       = skid_held;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      out_d        = bubble();
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (out_load) begin
      if (skid_valid_q) begin
        out_d        = skid_held;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        out_d       = in_entry;
        out_valid_d = 1'b1;
      end else begin
        out_d       = bubble();
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      // OUT is stalled: park the new entry so nothing upstream is lost.
      skid_d       = in_entry;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_q        <= bubble();
      out_valid_q  <= 1'b0;
      skid_q       <= bubble();
      skid_valid_q <= 1'b0;
    end else begin
      out_q        <= out_d;
      out_valid_q  <= out_valid_d;
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign out_valid       = out_valid_q;
  assign out_pc          = out_q.pc;
  assign out_instruction = out_q.instr;
  assign out_immediate   = out_q.imm;
  assign out_rs1_data    = out_q.rs1_val;
  assign out_rs2_data    = out_q.rs2_val;
  assign out_rd_addr     = out_q.rd;
  assign out_rs1_addr    = out_q.rs1;
  assign out_rs2_addr    = out_q.rs2;
  assign out_ctrl        = out_q.ctrl;

endmodule

// File: tb/tb_id_decode_pipe.sv
// Directed bench for id_decode_pipe: decode vector table plus hand-built
// hazard, backpressure, bypass, snoop, flush and reset sequences.
module tb_id_decode_pipe;
  logic        clk = 1'b0;
  logic        reset_n, flush, in_valid, in_ready, out_valid, out_ready, load_use_stall;
  logic [31:0] in_pc, in_instruction, rs1_data, rs2_data;
  logic [4:0]  rs1_addr, rs2_addr, out_rd_addr, out_rs1_addr, out_rs2_addr;
  logic [1:0]  wb_reg_write;
  logic [9:0]  wb_rd_addr;
  logic [63:0] wb_rd_data;
  logic [31:0] out_pc, out_instruction, out_immediate, out_rs1_data, out_rs2_data;
  logic [7:0]  out_ctrl;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  id_decode_pipe #(.NUM_WB(2), .CTRL_W(8), .MEMREAD_BIT(3)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instruction(in_instruction),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .wb_reg_write(wb_reg_write), .wb_rd_addr(wb_rd_addr), .wb_rd_data(wb_rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_instruction(out_instruction), .out_immediate(out_immediate),
    .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data),
    .out_rd_addr(out_rd_addr), .out_rs1_addr(out_rs1_addr), .out_rs2_addr(out_rs2_addr),
    .out_ctrl(out_ctrl), .load_use_stall(load_use_stall)
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [7:0]  ctrl;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
  } vec_t;

  vec_t tbl[10];

  function automatic logic [31:0] regval(input logic [4:0] a);
    return (a == 5'd0) ? 32'd0 : (32'h1000_0000 | {27'd0, a});
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc);
    in_valid       = v;
    in_instruction = instr;
    in_pc          = pc;
    rs1_data       = regval(instr[19:15]);
    rs2_data       = regval(instr[24:20]);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_entry(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                           input logic [31:0] imm, input logic [31:0] r1d, input logic [31:0] r2d,
                           input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [7:0] ctrl);
    chk({tag, ".valid"}, 32'(out_valid), 32'd1);
    chk({tag, ".pc"}, out_pc, pc);
    chk({tag, ".instr"}, out_instruction, instr);
    chk({tag, ".imm"}, out_immediate, imm);
    chk({tag, ".rs1_data"}, out_rs1_data, r1d);
    chk({tag, ".rs2_data"}, out_rs2_data, r2d);
    chk({tag, ".rd"}, 32'(out_rd_addr), 32'(rd));
    chk({tag, ".rs1"}, 32'(out_rs1_addr), 32'(rs1));
    chk({tag, ".rs2"}, 32'(out_rs2_addr), 32'(rs2));
    chk({tag, ".ctrl"}, 32'(out_ctrl), 32'(ctrl));
  endtask

  task automatic chk_bubble(input string tag);
    chk({tag, ".valid"}, 32'(out_valid), 32'd0);
    chk({tag, ".instr"}, out_instruction, 32'h0000_0013);
    chk({tag, ".ctrl"}, 32'(out_ctrl), 32'd0);
    chk({tag, ".pc"}, out_pc, 32'd0);
    chk({tag, ".imm"}, out_immediate, 32'd0);
    chk({tag, ".rs1_data"}, out_rs1_data, 32'd0);
    chk({tag, ".rs2_data"}, out_rs2_data, 32'd0);
    chk({tag, ".rd"}, 32'(out_rd_addr), 32'd0);
  endtask

  initial begin
    tbl[0] = '{32'h0050_0093, 32'h0000_0000, 32'h0000_0005, 8'h03,  5'd1,  5'd0, 5'd5};
    tbl[1] = '{32'hFFF1_8193, 32'h0000_0004, 32'hFFFF_FFFF, 8'h03,  5'd3,  5'd3, 5'd31};
    tbl[2] = '{32'h0020_A423, 32'h0000_0008, 32'h0000_0008, 8'h06,  5'd8,  5'd1, 5'd2};
    tbl[3] = '{32'hFE20_8EE3, 32'h0000_000C, 32'hFFFF_FFFC, 8'h20,  5'd29, 5'd1, 5'd2};
    tbl[4] = '{32'h1234_5537, 32'h0000_0010, 32'h1234_5000, 8'h03,  5'd10, 5'd8, 5'd3};
    tbl[5] = '{32'h0100_00EF, 32'h0000_0014, 32'h0000_0010, 8'h41,  5'd1,  5'd0, 5'd16};
    tbl[6] = '{32'h0000_1217, 32'h0000_0018, 32'h0000_1000, 8'h03,  5'd4,  5'd0, 5'd0};
    tbl[7] = '{32'h0000_8067, 32'h0000_001C, 32'h0000_0000, 8'h43,  5'd0,  5'd1, 5'd0};
    tbl[8] = '{32'h0022_8333, 32'h0000_0020, 32'h0000_0000, 8'h81,  5'd6,  5'd5, 5'd2};
    tbl[9] = '{32'h0000_A283, 32'h0000_0024, 32'h0000_0000, 8'h1B,  5'd5,  5'd1, 5'd0};

    reset_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
    wb_reg_write = 2'b00; wb_rd_addr = '0; wb_rd_data = '0;
    drive(1'b0, 32'h0000_0013, 32'd0);
    #12;
    chk_bubble("reset");
    reset_n = 1'b1;
    #1;
    chk("reset.in_ready", 32'(in_ready), 32'd1);

    // Decode table, one entry per cycle with out_ready held high.
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, tbl[i].instr, tbl[i].pc);
      #1;
      chk("vec.in_ready", 32'(in_ready), 32'd1);
      chk("vec.stall", 32'(load_use_stall), 32'd0);
      chk("vec.rs1_addr", 32'(rs1_addr), 32'(tbl[i].rs1));
      chk("vec.rs2_addr", 32'(rs2_addr), 32'(tbl[i].rs2));
      tick();
      $display("vec %0d pc=%h instr=%h out_valid=%0d", i, tbl[i].pc, tbl[i].instr, out_valid);
      chk_entry("vec", tbl[i].pc, tbl[i].instr, tbl[i].imm, regval(tbl[i].rs1), regval(tbl[i].rs2),
                tbl[i].rd, tbl[i].rs1, tbl[i].rs2, tbl[i].ctrl);
    end
    drive(1'b0, 32'h0000_0013, 32'd0);
    tick();
    chk_bubble("drain");

    // Load-use: lw x5,0(x1); add x6,x5,x2
    drive(1'b1, 32'h0000_A283, 32'h100);
    tick();
    $display("loaduse lw pc=%h out_valid=%0d", out_pc, out_valid);
    chk("lu.lw_pc", out_pc, 32'h100);
    drive(1'b1, 32'h0022_8333, 32'h104);
    #1;
    chk("lu.stall", 32'(load_use_stall), 32'd1);
    chk("lu.in_ready", 32'(in_ready), 32'd0);
    tick();
    chk_bubble("lu.bubble");
    chk("lu.stall_clear", 32'(load_use_stall), 32'd0);
    chk("lu.ready_back", 32'(in_ready), 32'd1);
    tick();
    $display("loaduse add pc=%h out_valid=%0d", out_pc, out_valid);
    chk_entry("lu.add", 32'h104, 32'h0022_8333, 32'd0, regval(5'd5), regval(5'd2),
              5'd6, 5'd5, 5'd2, 8'h81);
    drive(1'b0, 32'h0000_0013, 32'd0);
    tick();

    // Backpressure: three entries, out_ready low for three cycles.
    out_ready = 1'b0;
    drive(1'b1, 32'h0050_0093, 32'h200);
    tick();
    chk("bp.e1_pc", out_pc, 32'h200);
    drive(1'b1, 32'h0000_1217, 32'h204);
    #1;
    chk("bp.ready_skid", 32'(in_ready), 32'd1);
    tick();
    chk("bp.hold_e1", out_pc, 32'h200);
    drive(1'b1, 32'h1234_5537, 32'h208);
    #1;
    chk("bp.full_ready", 32'(in_ready), 32'd0);
    tick();
    chk("bp.still_e1", out_pc, 32'h200);
    chk("bp.still_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    #1;
    chk("bp.release_ready", 32'(in_ready), 32'd0);
    tick();
    $display("bp out pc=%h", out_pc);
    chk_entry("bp.e2", 32'h204, 32'h0000_1217, 32'h1000, 32'd0, 32'd0, 5'd4, 5'd0, 5'd0, 8'h03);
    chk("bp.ready_after", 32'(in_ready), 32'd1);
    tick();
    $display("bp out pc=%h", out_pc);
    chk_entry("bp.e3", 32'h208, 32'h1234_5537, 32'h1234_5000, regval(5'd8), regval(5'd3),
              5'd10, 5'd8, 5'd3, 8'h03);
    drive(1'b0, 32'h0000_0013, 32'd0);
    tick();
    chk_bubble("bp.empty");

    // Bypass priority: ports 0 and 1 both write x7.
    drive(1'b1, 32'h0013_8413, 32'h300);
    wb_reg_write = 2'b11;
    wb_rd_addr   = {5'd7, 5'd7};
    wb_rd_data   = {32'h0000_BBBB, 32'h0000_AAAA};
    tick();
    $display("byp both pc=%h rs1_data=%h", out_pc, out_rs1_data);
    chk("byp.both", out_rs1_data, 32'h0000_AAAA);
    chk("byp.rs2_untouched", out_rs2_data, regval(5'd1));
    drive(1'b1, 32'h0013_8413, 32'h304);
    wb_reg_write = 2'b10;
    tick();
    $display("byp port1 pc=%h rs1_data=%h", out_pc, out_rs1_data);
    chk("byp.port1", out_rs1_data, 32'h0000_BBBB);
    drive(1'b1, 32'h0010_0413, 32'h308);
    rs1_data     = 32'h0000_0055;
    wb_reg_write = 2'b11;
    wb_rd_addr   = {5'd0, 5'd0};
    wb_rd_data   = {32'h0000_BEEF, 32'h0000_DEAD};
    tick();
    $display("byp x0 pc=%h rs1_data=%h", out_pc, out_rs1_data);
    chk("byp.x0", out_rs1_data, 32'h0000_0055);
    wb_reg_write = 2'b00;
    drive(1'b0, 32'h0000_0013, 32'd0);
    tick();

    // Snoop: entry with rs2=x9 parked in SKID while port 1 writes x9.
    out_ready = 1'b0;
    drive(1'b1, 32'h0050_0093, 32'h400);
    tick();
    drive(1'b1, 32'h0092_8333, 32'h404);
    tick();
    drive(1'b0, 32'h0000_0013, 32'd0);
    wb_reg_write = 2'b10;
    wb_rd_addr   = {5'd9, 5'd9};
    wb_rd_data   = {32'h0000_1234, 32'h0000_FFFF};
    tick();
    wb_reg_write = 2'b00;
    tick();
    out_ready = 1'b1;
    tick();
    $display("snoop out pc=%h rs2_data=%h", out_pc, out_rs2_data);
    chk("snoop.pc", out_pc, 32'h404);
    chk("snoop.skid_rs2", out_rs2_data, 32'h0000_1234);
    chk("snoop.rs1", out_rs1_data, regval(5'd5));
    out_ready    = 1'b0;
    wb_reg_write = 2'b01;
    wb_rd_addr   = {5'd0, 5'd5};
    wb_rd_data   = {32'd0, 32'h0000_5555};
    tick();
    wb_reg_write = 2'b00;
    chk("snoop.out_rs1", out_rs1_data, 32'h0000_5555);
    chk("snoop.out_hold", out_pc, 32'h404);
    out_ready = 1'b1;
    tick();
    chk_bubble("snoop.drain");

    // Flush with OUT and SKID full and a new entry offered.
    out_ready = 1'b0;
    drive(1'b1, 32'h0050_0093, 32'h500);
    tick();
    drive(1'b1, 32'h0000_1217, 32'h504);
    tick();
    drive(1'b1, 32'h1234_5537, 32'h508);
    flush = 1'b1;
    #1;
    chk("flush.in_ready", 32'(in_ready), 32'd0);
    tick();
    $display("flush out_valid=%0d", out_valid);
    chk_bubble("flush");
    flush = 1'b0;
    drive(1'b0, 32'h0000_0013, 32'd0);
    #1;
    chk("flush.skid_empty", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    tick();
    chk("flush.no_ghost", 32'(out_valid), 32'd0);
    drive(1'b1, 32'h0050_0093, 32'h600);
    tick();
    chk("flush2.pc", out_pc, 32'h600);
    drive(1'b1, 32'h0000_1217, 32'h604);
    flush = 1'b1;
    tick();
    chk_bubble("flush2");
    flush = 1'b0;
    drive(1'b0, 32'h0000_0013, 32'd0);
    tick();
    chk("flush2.no_ghost", 32'(out_valid), 32'd0);

    // Asynchronous reset mid-stall discards both entries.
    out_ready = 1'b0;
    drive(1'b1, 32'h0050_0093, 32'h700);
    tick();
    drive(1'b1, 32'h0000_1217, 32'h704);
    tick();
    drive(1'b0, 32'h0000_0013, 32'd0);
    #2 reset_n = 1'b0;
    #1;
    $display("reset mid-stall out_valid=%0d", out_valid);
    chk_bubble("rst_mid");
    #2 reset_n = 1'b1;
    #1;
    chk("rst_mid.in_ready", 32'(in_ready), 32'd1);
    drive(1'b1, 32'h0000_8067, 32'h800);
    tick();
    chk_entry("rst_mid.first", 32'h800, 32'h0000_8067, 32'd0, regval(5'd1), 32'd0,
              5'd0, 5'd1, 5'd0, 8'h43);
    drive(1'b0, 32'h0000_0013, 32'd0);
    out_ready = 1'b1;
    tick();
    chk("rst_mid.skid_gone", 32'(out_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
